// File: rtl/reg_writeback_queue.sv
// Register writeback queue: in-order FIFO of {dst, data} results feeding one
// register file write port, with pending-write lookup for decode. Optional
// forwarding of the youngest matching entry when WB_BYPASS_EN is defined.
module reg_writeback_queue #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_dst,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 wb_stall,
    output logic                 wrt_en,
    output logic [3:0]           dst,
    output logic [BIT_WIDTH-1:0] dst_data,
    input  logic [3:0]           src1,
    input  logic [3:0]           src2,
    output logic                 src1_pend,
    output logic                 src2_pend,
    output logic [BIT_WIDTH-1:0] src1_fwd,
    output logic [BIT_WIDTH-1:0] src2_fwd,
    output logic [CW-1:0]        count
);

    logic [3:0]           r_dst  [DEPTH];
    logic [BIT_WIDTH-1:0] r_data [DEPTH];
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    logic w_push;
    logic w_pop;
    logic w_nonempty;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count < CW'(DEPTH));
    assign wrt_en     = w_nonempty && !wb_stall;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = wrt_en;
    assign dst        = w_nonempty ? r_dst[r_rd_ptr]  : '0;
    assign dst_data   = w_nonempty ? r_data[r_rd_ptr] : '0;
    assign count      = r_count;

    // Occupancy and pointers; reset only touches control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is never cleared; occupancy gates every lookup.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_dst[r_wr_ptr]  <= in_dst;
            r_data[r_wr_ptr] <= in_data;
        end
    end

    // Walk entries oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [AW-1:0] w_idx;
        logic          w_occ;
        src1_pend = 1'b0;
        src2_pend = 1'b0;
        src1_fwd  = '0;
        src2_fwd  = '0;
        w_idx     = '0;
        w_occ     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + AW'(i);
            w_occ = (CW'(i) < r_count);
            if (w_occ && (r_dst[w_idx] == src1)) begin
                src1_pend = 1'b1;
`ifdef WB_BYPASS_EN
                src1_fwd  = r_data[w_idx];
`endif
            end
            if (w_occ && (r_dst[w_idx] == src2)) begin
                src2_pend = 1'b1;
`ifdef WB_BYPASS_EN
                src2_fwd  = r_data[w_idx];
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue (DEPTH=4, BIT_WIDTH=32).
module tb_reg_writeback_queue;

    localparam int BW = 32;
    localparam int DP = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_dst;
    logic [BW-1:0] in_data;
    logic          wb_stall;
    logic          wrt_en;
    logic [3:0]    dst;
    logic [BW-1:0] dst_data;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          src1_pend;
    logic          src2_pend;
    logic [BW-1:0] src1_fwd;
    logic [BW-1:0] src2_fwd;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    reg_writeback_queue #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_data(in_data),
        .wb_stall(wb_stall), .wrt_en(wrt_en), .dst(dst), .dst_data(dst_data),
        .src1(src1), .src2(src2), .src1_pend(src1_pend), .src2_pend(src2_pend),
        .src1_fwd(src1_fwd), .src2_fwd(src2_fwd), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a settle delay.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dst   = d;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    logic [3:0]  exp_dst [$];
    logic [31:0] exp_dat [$];
    logic [31:0] fwd_exp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dst = '0; in_data = '0;
        wb_stall = 1'b0; src1 = 4'd0; src2 = 4'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wrt_en",   32'(wrt_en),   32'd0);
        check("rst_dst",      32'(dst),      32'd0);
        check("rst_dst_data", dst_data,      32'd0);
        check("rst_pend1",    32'(src1_pend), 32'd0);
        check("rst_pend2",    32'(src2_pend), 32'd0);
        check("rst_fwd1",     src1_fwd,      32'd0);
        check("rst_fwd2",     src2_fwd,      32'd0);
        check("rst_count",    32'(count),    32'd0);

        // Single entry, one-cycle latency to retire
        push(4'd3, 32'hDEADBEEF);
        #1;
        check("lat_wrt_en", 32'(wrt_en), 32'd1);
        check("lat_dst",    32'(dst),    32'd3);
        check("lat_data",   dst_data,    32'hDEADBEEF);
        check("lat_count",  32'(count),  32'd1);
        tick();
        check("lat_count0", 32'(count),  32'd0);
        check("lat_wrt0",   32'(wrt_en), 32'd0);

        // Fill while stalled, offer a fifth, then drain in order
        wb_stall = 1'b1;
        for (int k = 1; k <= 4; k++) push(4'(k), 32'h100 + 32'(k));
        #1;
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_wrt_en",   32'(wrt_en),   32'd0);
        push(4'd9, 32'h999);
        check("full_ignored",  32'(count),    32'd4);
        src1 = 4'd4; src2 = 4'd9;
        #1;
        check("full_pend4", 32'(src1_pend), 32'd1);
        check("full_pend9", 32'(src2_pend), 32'd0);
        wb_stall = 1'b0;
        in_valid = 1'b1; in_dst = 4'd9; in_data = 32'h999;
        #1;
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("drain_wrt_en", 32'(wrt_en), 32'd1);
            check("drain_dst",    32'(dst),    32'(k));
            check("drain_data",   dst_data,    32'h100 + 32'(k));
            tick();
            in_valid = 1'b0;
            if (k == 1) check("full_pop_count", 32'(count), 32'd3);
        end
        check("drain_count",  32'(count),  32'd0);
        check("drain_wrt_en0", 32'(wrt_en), 32'd0);

        // Duplicate destinations: youngest forwarded, both retained
        wb_stall = 1'b1;
        push(4'd5, 32'h11);
        push(4'd5, 32'h22);
        src1 = 4'd5; src2 = 4'd6;
        #1;
`ifdef WB_BYPASS_EN
        fwd_exp = 32'h22;
`else
        fwd_exp = 32'h0;
`endif
        check("dup_pend1", 32'(src1_pend), 32'd1);
        check("dup_fwd1",  src1_fwd,       fwd_exp);
        check("dup_pend2", 32'(src2_pend), 32'd0);
        check("dup_fwd2",  src2_fwd,       32'd0);
        check("dup_count", 32'(count),     32'd2);

        // Steady push+pop at count 2, enough cycles to wrap pointers
        exp_dst = '{4'd5, 4'd5};
        exp_dat = '{32'h11, 32'h22};
        wb_stall = 1'b0;
        for (int c = 0; c < DP + 4; c++) begin
            in_valid = 1'b1;
            in_dst   = (c == 0) ? 4'd7 : 4'(7 + c);
            in_data  = (c == 0) ? 32'h33 : 32'h3F + 32'(c);
            exp_dst.push_back(in_dst);
            exp_dat.push_back(in_data);
            #1;
            check("ss_wrt_en", 32'(wrt_en), 32'd1);
            check("ss_dst",    32'(dst),    32'(exp_dst.pop_front()));
            check("ss_data",   dst_data,    exp_dat.pop_front());
            tick();
            check("ss_count",  32'(count),  32'd2);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("tail_dst",  32'(dst), 32'(exp_dst.pop_front()));
            check("tail_data", dst_data, exp_dat.pop_front());
            tick();
        end
        check("tail_count", 32'(count), 32'd0);
        src1 = 4'd5; src2 = 4'd13;
        #1;
        check("stale_pend1", 32'(src1_pend), 32'd0);
        check("stale_pend2", 32'(src2_pend), 32'd0);

        // Reset discards queued entries and wins over a simultaneous push
        wb_stall = 1'b1;
        push(4'd1, 32'hA1);
        push(4'd2, 32'hA2);
        push(4'd3, 32'hA3);
        check("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1; in_valid = 1'b1; in_dst = 4'd4; in_data = 32'hA4;
        tick();
        rst = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
        src1 = 4'd4; src2 = 4'd1;
        #1;
        check("post_rst_count",    32'(count),     32'd0);
        check("post_rst_in_ready", 32'(in_ready),  32'd1);
        check("post_rst_pend1",    32'(src1_pend), 32'd0);
        check("post_rst_pend2",    32'(src2_pend), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("post_rst_wrt_en", 32'(wrt_en), 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16. CW = log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  producer offers a result.
REQ-006 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-007 SHALL have port in_dst  input  4  destination register index.
REQ-008 SHALL have port in_data  input  BIT_WIDTH  result value.
REQ-009 SHALL have port wb_stall  input  1  register file write port unavailable this cycle.
REQ-010 SHALL have port wrt_en  output  1  register file write enable.
REQ-011 SHALL have port dst  output  4  register file write index.
REQ-012 SHALL have port dst_data  output  BIT_WIDTH  register file write data.
REQ-013 SHALL have ports src1, src2  input  4 each  register indices being read by decode.
REQ-014 SHALL have ports src1_pend, src2_pend  output  1 each  queued write targets that source.
REQ-015 SHALL have ports src1_fwd, src2_fwd  output  BIT_WIDTH each  forwarded value.
REQ-016 SHALL have port count  output  CW  occupied entries.

Function
REQ-017 SHALL be a FIFO of {dst, data} entries, write order preserved.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinational from state only; no dependence on in_valid or wb_stall.
REQ-019 SHALL push on rising edge when in_valid && in_ready; in_valid without in_ready SHALL be ignored, no state change.
REQ-020 SHALL drive wrt_en = (count != 0) && !wb_stall, combinational; dst/dst_data SHALL equal head entry whenever count != 0, else 0.
REQ-021 SHALL pop head on the rising edge where wrt_en is 1; register file captures the same edge.
REQ-022 Latency: entry pushed at edge N into empty queue, wb_stall low, SHALL appear on wrt_en during cycle N..N+1 and retire at edge N+1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-024 Full queue with pop in the same cycle SHALL still hold in_ready low that cycle (no push-through at full).
REQ-025 srcN_pend SHALL be 1 iff any occupied entry, head included, has dst == srcN; combinational.
REQ-026 Multiple matching entries: srcN_fwd SHALL select the youngest (most recently pushed) match.
REQ-027 Entries with equal dst SHALL all be written, oldest first; none merged or dropped.

Reset
REQ-028 With rst high at a rising edge, SHALL clear count, read and write pointers; queued entries discarded, never written.
REQ-029 After reset SHALL present: in_ready=1, wrt_en=0, dst=0, dst_data=0, srcN_pend=0, srcN_fwd=0, count=0.
REQ-030 rst SHALL take priority over simultaneous push and pop in the same cycle.
REQ-031 Entry storage contents need not be cleared; occupancy gating alone SHALL suppress stale matches.

Configuration
REQ-032 Macro WB_BYPASS_EN defined: srcN_fwd SHALL carry youngest matching entry data when srcN_pend=1, else 0.
REQ-033 Macro WB_BYPASS_EN undefined: srcN_fwd SHALL be constant 0, no match-data mux built; srcN_pend behaviour unchanged (decode stalls instead).

Verification
REQ-034 Reset then push {dst=3, data=0xDEADBEEF}, wb_stall=0 -> next cycle wrt_en=1, dst=3, dst_data=0xDEADBEEF, count=1; following cycle count=0, wrt_en=0.
REQ-035 wb_stall=1, push 4 entries (dst 1..4) -> count=4, in_ready=0, wrt_en=0; 5th offer ignored; release stall -> writes dst 1,2,3,4 on 4 consecutive cycles.
REQ-036 Queue holds {5,0x11} then {5,0x22}, stalled, src1=5 -> src1_pend=1, src1_fwd=0x22 with WB_BYPASS_EN, 0 without; src2=6 -> src2_pend=0.
REQ-037 count=2, push and pop same cycle -> count stays 2; after DEPTH+3 pushes/pops pointers wrap, write order intact.
REQ-038 count=3 stalled, assert rst one cycle with in_valid=1 -> count=0, no wrt_en pulse afterwards, in_ready=1.
